// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: A - B - Bin, one bit per clock, LSB first, with a
// second serial two's-complement pass that produces the magnitude of negative results.
module serial_subtractor #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             bin_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] y_o,
    output logic             bout_o,
    output logic             neg_o,
    output logic [WIDTH:0]   mag_o
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 2);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SUB  = 2'd1;
    localparam logic [1:0] S_NEG  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       state_q,  state_d;
    logic [WIDTH-1:0] a_sr_q,   a_sr_d;
    logic [WIDTH-1:0] b_sr_q,   b_sr_d;
    logic             brw_q,    brw_d;
    logic [WIDTH-1:0] diff_q,   diff_d;
    logic [WIDTH:0]   neg_sr_q, neg_sr_d;
    logic             carry_q,  carry_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;
    logic [WIDTH-1:0] y_q,      y_d;
    logic             bout_q,   bout_d;
    logic             neg_q,    neg_d;
    logic [WIDTH:0]   mag_q,    mag_d;

    // Full-subtractor bit and serial-negate bit for the current LSBs
    logic d_bit_c, brw_nx_c, m_bit_c, carry_nx_c;
    assign d_bit_c    = a_sr_q[0] ^ b_sr_q[0] ^ brw_q;
    assign brw_nx_c   = (~a_sr_q[0] & b_sr_q[0]) | (~a_sr_q[0] & brw_q) | (b_sr_q[0] & brw_q);
    assign m_bit_c    = ~neg_sr_q[0] ^ carry_q;
    assign carry_nx_c = ~neg_sr_q[0] & carry_q;

    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        brw_d    = brw_q;
        diff_d   = diff_q;
        neg_sr_d = neg_sr_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        y_d      = y_q;
        bout_d   = bout_q;
        neg_d    = neg_q;
        mag_d    = mag_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    a_sr_d  = a_i;
                    b_sr_d  = b_i;
                    brw_d   = bin_i;
                    cnt_d   = '0;
                    state_d = S_SUB;
                end
            end
            S_SUB: begin
                a_sr_d = a_sr_q >> 1;
                b_sr_d = b_sr_q >> 1;
                brw_d  = brw_nx_c;
                diff_d = {d_bit_c, diff_q[WIDTH-1:1]};
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    if (brw_nx_c) begin
                        neg_sr_d = {brw_nx_c, d_bit_c, diff_q[WIDTH-1:1]};
                        carry_d  = 1'b1;
                        cnt_d    = '0;
                        state_d  = S_NEG;
                    end else begin
                        y_d     = {d_bit_c, diff_q[WIDTH-1:1]};
                        bout_d  = 1'b0;
                        neg_d   = 1'b0;
                        mag_d   = {1'b0, d_bit_c, diff_q[WIDTH-1:1]};
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_NEG: begin
                neg_sr_d = {m_bit_c, neg_sr_q[WIDTH:1]};
                carry_d  = carry_nx_c;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH)) begin
                    y_d     = diff_q;
                    bout_d  = 1'b1;
                    neg_d   = 1'b1;
                    mag_d   = {m_bit_c, neg_sr_q[WIDTH:1]};
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            brw_q    <= 1'b0;
            diff_q   <= '0;
            neg_sr_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            y_q      <= '0;
            bout_q   <= 1'b0;
            neg_q    <= 1'b0;
            mag_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            brw_q    <= brw_d;
            diff_q   <= diff_d;
            neg_sr_q <= neg_sr_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            y_q      <= y_d;
            bout_q   <= bout_d;
            neg_q    <= neg_d;
            mag_q    <= mag_d;
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign y_o    = y_q;
    assign bout_o = bout_q;
    assign neg_o  = neg_q;
    assign mag_o  = mag_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed corner cases plus random
// operands compared against a plain integer-arithmetic reference.
module tb_serial_subtractor;

    localparam int W = 4;

    logic         clk;
    logic         reset;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         bin_in;
    logic         busy_o;
    logic         done_o;
    logic [W-1:0] y_o;
    logic         bout_o;
    logic         neg_o;
    logic [W:0]   mag_o;

    int checks   = 0;
    int failures = 0;
    logic [31:0] prev_y = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .start_i (start),
        .a_i     (a_in),
        .b_i     (b_in),
        .bin_i   (bin_in),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .y_o     (y_o),
        .bout_o  (bout_o),
        .neg_o   (neg_o),
        .mag_o   (mag_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check_eq({tag, "_busy"}, 32'(busy_o), 0);
        check_eq({tag, "_done"}, 32'(done_o), 0);
        check_eq({tag, "_y"},    32'(y_o),    0);
        check_eq({tag, "_bout"}, 32'(bout_o), 0);
        check_eq({tag, "_neg"},  32'(neg_o),  0);
        check_eq({tag, "_mag"},  32'(mag_o),  0);
    endtask

    // One operation; edge 0 accepts start. inj_k > 0 raises a stray start after edge inj_k.
    task automatic run_op(input int a, input int b, input int bin, input int inj_k);
        int diff;
        int exp_k;
        int ndone;
        int first_k;
        logic [31:0] exp_y;
        logic [31:0] exp_mag;
        diff    = a - b - bin;
        exp_k   = (diff < 0) ? 2 * W + 1 : W;
        exp_y   = 32'(diff & ((1 << W) - 1));
        exp_mag = 32'((diff < 0) ? -diff : diff);
        ndone   = 0;
        first_k = -1;

        start  = 1'b1;
        a_in   = W'(a);
        b_in   = W'(b);
        bin_in = 1'(bin);
        @(posedge clk); #1;
        start  = 1'b0;
        a_in   = W'($urandom_range(0, (1 << W) - 1));
        b_in   = W'($urandom_range(0, (1 << W) - 1));
        bin_in = 1'($urandom_range(0, 1));
        check_eq("busy_after_start", 32'(busy_o), 1);
        check_eq("y_held", 32'(y_o), prev_y);

        for (int k = 1; k <= exp_k + 2; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (done_o) begin
                ndone++;
                if (first_k < 0) first_k = k;
            end
            if (k == exp_k) begin
                check_eq("y",    32'(y_o),    exp_y);
                check_eq("bout", 32'(bout_o), 32'(diff < 0));
                check_eq("neg",  32'(neg_o),  32'(diff < 0));
                check_eq("mag",  32'(mag_o),  exp_mag);
                check_eq("busy_in_done", 32'(busy_o), 1);
            end
            if (k == inj_k) begin
                start  = 1'b1;
                a_in   = W'(1);
                b_in   = W'(8);
                bin_in = 1'b0;
            end
        end
        check_eq("done_pulses",  32'(ndone),   1);
        check_eq("done_latency", 32'(first_k), 32'(exp_k));
        check_eq("busy_after",   32'(busy_o),  0);
        check_eq("y_hold_after", 32'(y_o),     exp_y);
        prev_y = exp_y;
    endtask

    initial begin
        int ndone;
        reset  = 1'b1;
        start  = 1'b0;
        a_in   = '0;
        b_in   = '0;
        bin_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_idle_zero("reset");
        repeat (3) @(posedge clk);
        #1;
        check_idle_zero("idle");

        run_op(9, 3, 0, 0);
        run_op(3, 9, 0, 0);
        run_op(0, 15, 1, 0);
        run_op(7, 7, 0, 0);
        run_op(7, 7, 1, 0);
        run_op(9, 3, 0, 1);
        run_op(15, 0, 0, 0);
        run_op(0, 0, 1, 0);

        // Reset during the NEGATE pass aborts the operation
        start = 1'b1;
        a_in  = W'(3);
        b_in  = W'(9);
        bin_in = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            if (done_o) ndone++;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_idle_zero("abort");
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (done_o) ndone++;
        end
        check_eq("abort_no_done", 32'(ndone), 0);
        prev_y = 0;
        run_op(5, 2, 0, 0);

        for (int n = 0; n < 40; n++) begin
            run_op(int'($urandom_range(0, (1 << W) - 1)),
                   int'($urandom_range(0, (1 << W) - 1)),
                   int'($urandom_range(0, 1)), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
